// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide DataMemory without byte enables.
// Extends narrow loads, does read-modify-write for narrow stores, and flags bad requests.
module load_store_unit #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, RESP} state_t;

  state_t      state, state_n;
  logic [2:0]  op_q, op_n;
  logic [1:0]  lane_q, lane_n;
  logic [31:0] wdata_q, wdata_n;
  logic [2:0]  cnt_q, cnt_n;
  logic        req_ready_n, resp_valid_n, resp_err_n, mem_read_n, mem_write_n;
  logic [31:0] resp_rdata_n, mem_address_n, mem_write_data_n;
  logic        accept, bad_align, bad_range, bad_op, bad;
  logic [31:0] word_idx;

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [1:0] lane,
                                         input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_B:    extend = {{24{b[7]}}, b};
      OP_BU:   extend = {24'b0, b};
      OP_H:    extend = {{16{h[15]}}, h};
      OP_HU:   extend = {16'b0, h};
      default: extend = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] lane,
                                        input logic [31:0] word, input logic [31:0] wdata);
    merge = word;
    if (op == OP_H) begin
      if (lane[1]) merge[31:16] = wdata[15:0];
      else         merge[15:0]  = wdata[15:0];
    end else begin
      merge[{lane, 3'b000} +: 8] = wdata[7:0];
    end
  endfunction

  always_comb begin
    word_idx  = {2'b00, req_addr[31:2]};
    bad_align = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                ((req_op == OP_W) && (req_addr[1:0] != 2'b00));
    bad_range = word_idx >= 32'(DEPTH);
    bad_op    = (req_op == 3'b011) || (req_op == 3'b110) || (req_op == 3'b111) ||
                (req_we && req_op[2]);
    bad       = bad_align || bad_range || bad_op;
    accept    = req_valid && req_ready;
  end

  // Registered outputs are computed here as next values and only change on strobe/response events.
  always_comb begin
    state_n          = state;
    op_n             = op_q;
    lane_n           = lane_q;
    wdata_n          = wdata_q;
    cnt_n            = cnt_q;
    req_ready_n      = req_ready;
    resp_valid_n     = resp_valid;
    resp_err_n       = resp_err;
    resp_rdata_n     = resp_rdata;
    mem_read_n       = 1'b0;
    mem_write_n      = 1'b0;
    mem_address_n    = mem_address;
    mem_write_data_n = mem_write_data;
    case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        if (accept) begin
          req_ready_n  = 1'b0;
          op_n         = req_op;
          lane_n       = req_addr[1:0];
          wdata_n      = req_wdata;
          resp_rdata_n = '0;
          resp_err_n   = 1'b0;
          if (bad) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else begin
            mem_address_n = word_idx;
            if (!req_we) begin
              state_n    = RD;
              mem_read_n = 1'b1;
            end else if (req_op == OP_W) begin
              state_n          = WR;
              mem_write_n      = 1'b1;
              mem_write_data_n = req_wdata;
            end else begin
              state_n    = RMW_RD;
              mem_read_n = 1'b1;
            end
          end
        end
      end
      RD: begin
        state_n = RD_WAIT;
        cnt_n   = WAIT_INIT;
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_n      = RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = extend(op_q, lane_q, mem_read_data);
        end else begin
          cnt_n = cnt_q - 3'd1;
        end
      end
      RMW_RD: begin
        state_n = RMW_WAIT;
        cnt_n   = WAIT_INIT;
      end
      RMW_WAIT: begin
        if (cnt_q == '0) begin
          state_n          = WR;
          mem_write_n      = 1'b1;
          mem_write_data_n = merge(op_q, lane_q, mem_read_data, wdata_q);
        end else begin
          cnt_n = cnt_q - 3'd1;
        end
      end
      WR: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_n      = IDLE;
          resp_valid_n = 1'b0;
          resp_err_n   = 1'b0;
          resp_rdata_n = '0;
          req_ready_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= '0;
      lane_q         <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      state          <= state_n;
      op_q           <= op_n;
      lane_q         <= lane_n;
      wdata_q        <= wdata_n;
      cnt_q          <= cnt_n;
      req_ready      <= req_ready_n;
      resp_valid     <= resp_valid_n;
      resp_err       <= resp_err_n;
      resp_rdata     <= resp_rdata_n;
      mem_read       <= mem_read_n;
      mem_write      <= mem_write_n;
      mem_address    <= mem_address_n;
      mem_write_data <= mem_write_data_n;
    end
  end

endmodule
